// File: rtl/med_pkg.sv
// Shared state encoding and sizing helpers for the MED median sequencer.
package med_pkg;

  localparam int NBITS_DEF   = 8;
  localparam int NPIXELS_DEF = 9;

  typedef enum logic [2:0] {IDLE, LOAD, CMP, BYPS, CAPT} med_state_t;

  function automatic int med_npass(input int npixels);
    return (npixels + 1) / 2;
  endfunction

  // Cycles from the first CMP cycle up to (not including) CAPT.
  function automatic int med_sort_len(input int npixels);
    return (npixels - 1) * med_npass(npixels) + med_npass(npixels) - 1;
  endfunction

endpackage

// File: rtl/med_win_buf.sv
// Window buffer: pixels written sequentially from the upstream stream,
// read by index during the LOAD burst, released in one cycle.
module med_win_buf
  import med_pkg::*;
#(
  parameter int NBITS   = NBITS_DEF,
  parameter int NPIXELS = NPIXELS_DEF,
  parameter int CW      = $clog2(NPIXELS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NBITS-1:0] pix_data,
  input  logic             pix_valid,
  output logic             pix_ready,
  input  logic             release_win,
  input  logic [CW-1:0]    rd_idx,
  output logic [NBITS-1:0] rd_data,
  output logic             full
);

  logic [NBITS-1:0] mem [NPIXELS];
  logic [CW-1:0]    wr_cnt;
  logic             accept;

  assign full      = (wr_cnt == CW'(NPIXELS));
  assign pix_ready = ~full & ~rst;
  assign accept    = pix_valid & pix_ready;
  assign rd_data   = mem[rd_idx];

  // Release only happens while full, so it never collides with a write.
  always_ff @(posedge clk) begin
    if (rst || release_win) wr_cnt <= '0;
    else if (accept)        wr_cnt <= wr_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wr_cnt] <= pix_data;
  end

endmodule

// File: rtl/med_ctrl.sv
// Sequencer for the MED median datapath: bursts a buffered window into MED,
// walks the compare/bypass schedule and holds the captured median.
module med_ctrl
  import med_pkg::*;
#(
  parameter int NBITS   = NBITS_DEF,
  parameter int NPIXELS = NPIXELS_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [NBITS-1:0] PIX_DATA,
  input  logic             PIX_VALID,
  output logic             PIX_READY,
  output logic [NBITS-1:0] MED_DI,
  output logic             MED_DSI,
  output logic             MED_BYP,
  input  logic [NBITS-1:0] MED_DO,
  output logic [NBITS-1:0] RES_DATA,
  output logic             RES_VALID,
  input  logic             RES_READY,
  output logic             BUSY
);

  localparam int NPASS = med_npass(NPIXELS);
  localparam int CW    = $clog2(NPIXELS + 1);
  localparam int SW    = $clog2(NPIXELS);
  localparam int PW    = $clog2(NPASS);

  med_state_t       state, state_nxt;
  logic [CW-1:0]    rd_cnt;
  logic [SW-1:0]    seg_cnt;
  logic [PW-1:0]    pass_cnt;
  logic             buf_full;
  logic             load_last, seg_last, pass_last;
  logic [NBITS-1:0] buf_rd;

  med_win_buf #(
    .NBITS   (NBITS),
    .NPIXELS (NPIXELS)
  ) u_buf (
    .clk         (CLK),
    .rst         (RST),
    .pix_data    (PIX_DATA),
    .pix_valid   (PIX_VALID),
    .pix_ready   (PIX_READY),
    .release_win (load_last),
    .rd_idx      (rd_cnt),
    .rd_data     (buf_rd),
    .full        (buf_full)
  );

  assign load_last = (state == LOAD) && (rd_cnt == CW'(NPIXELS - 1));
  assign seg_last  = (state == CMP)  && (seg_cnt == SW'(NPIXELS - 2));
  assign pass_last = (pass_cnt == PW'(NPASS - 1));
  assign BUSY      = (state != IDLE);

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // Start only when the result slot is free: MED has no clock enable,
  // so a started sort must always be able to deposit its result.
  always_comb begin
    state_nxt = state;
    MED_DSI   = 1'b0;
    MED_BYP   = 1'b1;
    MED_DI    = '0;
    case (state)
      IDLE: if (buf_full && !RES_VALID) state_nxt = LOAD;
      LOAD: begin
        MED_DSI = 1'b1;
        MED_DI  = buf_rd;
        if (load_last) state_nxt = CMP;
      end
      CMP: begin
        MED_BYP = 1'b0;
        if (seg_last) state_nxt = pass_last ? CAPT : BYPS;
      end
      BYPS:    state_nxt = CMP;
      CAPT:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_cnt   <= '0;
      seg_cnt  <= '0;
      pass_cnt <= '0;
    end else begin
      case (state)
        IDLE: rd_cnt <= '0;
        LOAD: begin
          if (!load_last) rd_cnt <= rd_cnt + 1'b1;
          seg_cnt  <= '0;
          pass_cnt <= '0;
        end
        CMP:     seg_cnt  <= seg_last ? '0 : seg_cnt + 1'b1;
        BYPS:    pass_cnt <= pass_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  // Result holding register with valid/ready.
  always_ff @(posedge CLK) begin
    if (RST) begin
      RES_VALID <= 1'b0;
      RES_DATA  <= '0;
    end else if (state == CAPT) begin
      RES_VALID <= 1'b1;
      RES_DATA  <= MED_DO;
    end else if (RES_VALID && RES_READY) begin
      RES_VALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_med_ctrl.sv
// Directed bench for med_ctrl with a behavioural MED that only presents the
// true median on DO when sampled exactly at the end of the sort schedule.
`timescale 1ns/1ps
module tb_med_ctrl;

  localparam int LOGN = 4096;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] PIX_DATA;
  logic       PIX_VALID;
  logic       PIX_READY;
  logic [7:0] MED_DI;
  logic       MED_DSI;
  logic       MED_BYP;
  logic [7:0] MED_DO;
  logic [7:0] RES_DATA;
  logic       RES_VALID;
  logic       RES_READY;
  logic       BUSY;

  med_ctrl #(.NBITS(8), .NPIXELS(9)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .PIX_DATA  (PIX_DATA),
    .PIX_VALID (PIX_VALID),
    .PIX_READY (PIX_READY),
    .MED_DI    (MED_DI),
    .MED_DSI   (MED_DSI),
    .MED_BYP   (MED_BYP),
    .MED_DO    (MED_DO),
    .RES_DATA  (RES_DATA),
    .RES_VALID (RES_VALID),
    .RES_READY (RES_READY),
    .BUSY      (BUSY)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // MED model: shift-in on DSI, counts cycles since the last shift.
  logic [7:0] ring [9] = '{default: 8'h00};
  int         sortc = 1000;

  function automatic logic [7:0] med9(input logic [7:0] a [9]);
    logic [7:0] t [9];
    logic [7:0] x;
    t = a;
    for (int i = 0; i < 9; i++)
      for (int j = 0; j < 8 - i; j++)
        if (t[j] > t[j+1]) begin x = t[j]; t[j] = t[j+1]; t[j+1] = x; end
    return t[4];
  endfunction

  always @(posedge CLK) begin
    if (MED_DSI) begin
      for (int i = 8; i > 0; i--) ring[i] <= ring[i-1];
      ring[0] <= MED_DI;
      sortc   <= 0;
    end else if (sortc < 1000) begin
      sortc <= sortc + 1;
    end
  end

  assign MED_DO = (sortc == 44) ? med9(ring) : ~med9(ring);

  // Per-cycle log of DUT outputs, sampled mid-cycle.
  bit         dsi_log  [LOGN];
  bit         byp_log  [LOGN];
  bit         busy_log [LOGN];
  bit         prdy_log [LOGN];
  logic [7:0] di_log   [LOGN];
  bit         started = 1'b0;
  int         xcnt = 0;

  always @(negedge CLK) begin
    if (cyc < LOGN) begin
      dsi_log[cyc]  = MED_DSI;
      byp_log[cyc]  = MED_BYP;
      busy_log[cyc] = BUSY;
      prdy_log[cyc] = PIX_READY;
      di_log[cyc]   = MED_DI;
    end
    if (started && $isunknown({PIX_READY, MED_DI, MED_DSI, MED_BYP, RES_DATA, RES_VALID, BUSY}))
      xcnt++;
  end

  int n_chk  = 0;
  int n_fail = 0;
  int last_xfer = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic send_px(input logic [7:0] d);
    int w = 0;
    PIX_DATA  = d;
    PIX_VALID = 1'b1;
    while (PIX_READY !== 1'b1 && w < 500) begin @(negedge CLK); w++; end
    if (w >= 500) chk("pix_ready_timeout", PIX_READY, 1);
    last_xfer = cyc;
    @(negedge CLK);
    PIX_VALID = 1'b0;
  endtask

  task automatic wait_rv(output int c);
    int w = 0;
    do begin @(negedge CLK); w++; end while (RES_VALID !== 1'b1 && w < 300);
    chk("res_valid_arrives", RES_VALID, 1);
    c = cyc;
  endtask

  function automatic int first_dsi(input int from);
    for (int k = from; k < cyc && k < LOGN; k++)
      if (dsi_log[k]) return k;
    return -1;
  endfunction

  task automatic check_burst(input string tag, input int l, input logic [7:0] px [9]);
    int n = 0;
    for (int k = l - 1; k <= l + 10; k++) if (dsi_log[k]) n++;
    chk({tag, "_dsi_len"}, n, 9);
    for (int k = 0; k < 9; k++) chk({tag, "_di_order"}, di_log[l+k], px[k]);
  endtask

  task automatic check_sort(input string tag, input int l, input int rv_c);
    logic [63:0] got_b = '0;
    logic [63:0] exp_b = '0;
    for (int k = 0; k < 44; k++) begin
      got_b[k] = byp_log[l+9+k];
      exp_b[k] = (k % 9 == 8);
    end
    chk({tag, "_byp_pattern"}, got_b, exp_b);
    chk({tag, "_capt_byp"},    byp_log[l+53], 1);
    chk({tag, "_capt_busy"},   busy_log[l+53], 1);
    chk({tag, "_idle_after"},  busy_log[l+54], 0);
    chk({tag, "_latency"},     rv_c - l, 54);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  logic [7:0] t1 [9], t2 [9], wa [9], wb [9], wc [9], wd [9], wf [9];
  int L, L2, rv_c, rv2, xfer9, xb_first, xb_last, R, bad, base, w;

  initial begin
    RST = 1'b1; PIX_DATA = '0; PIX_VALID = 1'b0; RES_READY = 1'b1;
    repeat (3) @(negedge CLK);
    chk("rst_res_valid", RES_VALID, 0);
    chk("rst_res_data",  RES_DATA, 0);
    chk("rst_dsi",       MED_DSI, 0);
    chk("rst_byp",       MED_BYP, 1);
    chk("rst_di",        MED_DI, 0);
    chk("rst_busy",      BUSY, 0);
    chk("rst_pix_ready", PIX_READY, 0);
    RST = 1'b0; started = 1'b1;
    #1 chk("pix_ready_after_rst", PIX_READY, 1);
    @(negedge CLK);

    // Back-to-back window, median 5
    t1 = '{8'd9, 8'd1, 8'd8, 8'd2, 8'd7, 8'd3, 8'd6, 8'd4, 8'd5};
    base = cyc;
    for (int i = 0; i < 9; i++) send_px(t1[i]);
    xfer9 = last_xfer;
    wait_rv(rv_c);
    chk("t1_res", RES_DATA, 8'd5);
    repeat (2) @(negedge CLK);
    L = first_dsi(base);
    chk("t1_load_start", L, xfer9 + 2);
    if (L < 1) L = 1;
    check_burst("t1", L, t1);
    check_sort("t1", L, rv_c);

    // Gapped valid, median 4
    t2 = '{8'd3, 8'd1, 8'd4, 8'd1, 8'd5, 8'd9, 8'd2, 8'd6, 8'd5};
    base = cyc;
    for (int i = 0; i < 9; i++) begin send_px(t2[i]); @(negedge CLK); end
    xfer9 = last_xfer;
    wait_rv(rv_c);
    chk("t2_res", RES_DATA, 8'd4);
    repeat (2) @(negedge CLK);
    L = first_dsi(base);
    chk("t2_load_start", L, xfer9 + 2);
    if (L < 1) L = 1;
    check_burst("t2", L, t2);

    // Second window collected during the first sort
    wa = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80, 8'd90};
    wb = '{8'd5, 8'd200, 8'd7, 8'd150, 8'd9, 8'd100, 8'd11, 8'd90, 8'd13};
    base = cyc;
    for (int i = 0; i < 9; i++) send_px(wa[i]);
    xb_first = 0;
    for (int i = 0; i < 9; i++) begin
      send_px(wb[i]);
      if (i == 0) xb_first = last_xfer;
    end
    xb_last = last_xfer;
    wait_rv(rv_c);
    chk("t3_res_a", RES_DATA, 8'd50);
    wait_rv(rv2);
    chk("t3_res_b", RES_DATA, 8'd13);
    repeat (2) @(negedge CLK);
    L = first_dsi(base);
    if (L < 1) L = 1;
    L2 = first_dsi(L + 10);
    chk("t3_load2_gap", L2 - (L + 53), 3);
    if (L2 < 1) L2 = 1;
    chk("t3_ready_full",   prdy_log[L+8], 0);
    chk("t3_ready_rise",   prdy_log[L+9], 1);
    chk("t3_b_first_xfer", xb_first, L + 9);
    chk("t3_b_last_xfer",  xb_last, L + 17);
    chk("t3_ready_drop",   prdy_log[L+18], 0);
    check_burst("t3b", L2, wb);
    check_sort("t3b", L2, rv2);

    // Downstream stalled with the next window already full
    RES_READY = 1'b0;
    wc = '{8'd29, 8'd21, 8'd28, 8'd22, 8'd27, 8'd23, 8'd26, 8'd24, 8'd25};
    wd = '{default: 8'd77};
    for (int i = 0; i < 9; i++) send_px(wc[i]);
    for (int i = 0; i < 9; i++) send_px(wd[i]);
    wait_rv(rv_c);
    chk("t4_res_c", RES_DATA, 8'd25);
    bad = 0;
    repeat (100) begin
      @(negedge CLK);
      if (RES_DATA !== 8'd25 || RES_VALID !== 1'b1 || BUSY !== 1'b0 ||
          MED_DSI !== 1'b0 || PIX_READY !== 1'b0) bad++;
    end
    chk("t4_hold_stable", bad, 0);
    RES_READY = 1'b1;
    R = cyc;
    wait_rv(rv2);
    chk("t4_res_d", RES_DATA, 8'd77);
    repeat (2) @(negedge CLK);
    L2 = first_dsi(R);
    chk("t4_load_after_clear", L2, R + 2);

    // Reset in the middle of the third CMP pass
    for (int i = 0; i < 9; i++) send_px(8'(i + 1));
    w = 0;
    while (MED_DSI !== 1'b1 && w < 100) begin @(negedge CLK); w++; end
    chk("t5_load_seen", MED_DSI, 1);
    repeat (29) @(negedge CLK);
    chk("t5_in_cmp", MED_BYP, 0);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("t5_rv_after_rst",   RES_VALID, 0);
    chk("t5_busy_after_rst", BUSY, 0);
    chk("t5_prdy_after_rst", PIX_READY, 1);
    chk("t5_byp_after_rst",  MED_BYP, 1);
    @(negedge CLK);
    wf = '{default: 8'hFF};
    for (int i = 0; i < 9; i++) send_px(wf[i]);
    wait_rv(rv_c);
    chk("t5_res_ff", RES_DATA, 8'hFF);

    // Edge values
    wf = '{default: 8'h00};
    for (int i = 0; i < 9; i++) send_px(wf[i]);
    wait_rv(rv_c);
    chk("t6_res_zero", RES_DATA, 8'h00);
    for (int i = 0; i < 9; i++) send_px((i % 2 == 0) ? 8'h00 : 8'hFF);
    wait_rv(rv_c);
    chk("t6_res_alt0", RES_DATA, 8'h00);
    for (int i = 0; i < 9; i++) send_px((i % 2 == 0) ? 8'hFF : 8'h00);
    wait_rv(rv_c);
    chk("t6_res_altff", RES_DATA, 8'hFF);

    repeat (3) @(negedge CLK);
    chk("no_x_outputs", xcnt, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
